// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC sequencing controller.
// Holds the controller state encoding and the default widths used by
// mac_ctrl and mac_tap_cnt.
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int TAP_W_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_tap_cnt.sv
// mac_tap_cnt: counts operand pairs accepted by the controller.
// tc flags that the next accepted pair is the final one of the job, so the
// controller can leave RUN on that same acceptance. The count only reaches
// num_taps, which always fits in TAP_W bits, so it never wraps.
module mac_tap_cnt
    import mac_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk_gated,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TAP_W-1:0] last,
    output logic             tc
);

    logic [TAP_W-1:0] count;

    // Pair counter: cleared at the start of each job, advanced per accepted pair.
    always_ff @(posedge clk_gated or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TAP_W'(1);
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequences an external multiply-accumulate datapath through one
// dot product of num_taps operand pairs and captures the accumulator value.
// Optional build macro: MAC_CTRL_RELU_EN -- when defined, a negative
// accumulator value is captured as zero.
module mac_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int TAP_W  = TAP_W_DEF
) (
    input  logic                     clk_gated,
    input  logic                     rst,
    input  logic                     start,
    input  logic [TAP_W-1:0]         num_taps,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] pixel_in,
    input  logic signed [DATA_W-1:0] kernel_in,
    output logic                     mac_start,
    output logic                     mac_rst_n,
    output logic signed [DATA_W-1:0] mac_pixel,
    output logic signed [DATA_W-1:0] mac_kernel,
    input  logic signed [ACC_W-1:0]  mac_result,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  result
);

    state_t           state;
    state_t           state_nxt;
    logic [TAP_W-1:0] taps_q;
    logic             cnt_clr;
    logic             cnt_tc;

    // Result conditioning applied when the accumulator is captured.
    function automatic logic signed [ACC_W-1:0] capture_fn(input logic signed [ACC_W-1:0] v);
`ifdef MAC_CTRL_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    mac_tap_cnt #(
        .TAP_W (TAP_W)
    ) u_tap_cnt (
        .clk_gated (clk_gated),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (mac_start),
        .last      (taps_q - TAP_W'(1)),
        .tc        (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk_gated or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tap count is latched only when a start is accepted from IDLE.
    always_ff @(posedge clk_gated or negedge rst) begin
        if (!rst) begin
            taps_q <= '0;
        end else if (state == IDLE && start) begin
            taps_q <= num_taps;
        end
    end

    // Result is zeroed for each new job and loaded at the end of DRAIN.
    always_ff @(posedge clk_gated or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else if (state == CLEAR) begin
            result <= '0;
        end else if (state == DRAIN && !abort) begin
            result <= capture_fn(mac_result);
        end
    end

    // Next-state and outputs; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mac_start  = 1'b0;
        mac_pixel  = '0;
        mac_kernel = '0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        mac_rst_n  = rst;
        cnt_clr    = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                mac_rst_n = 1'b0;
                cnt_clr   = 1'b1;
                state_nxt = (taps_q != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready   = 1'b1;
                mac_start  = in_valid;
                mac_pixel  = pixel_in;
                mac_kernel = kernel_in;
                if (in_valid && cnt_tc) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            in_ready  = 1'b0;
            mac_start = 1'b0;
            out_valid = 1'b0;
            mac_rst_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: directed bench for mac_ctrl with a behavioural accumulator
// standing in for the datapath and a result scoreboard.
module tb_mac_ctrl;

    logic               clk_gated = 1'b0;
    logic               rst;
    logic               start;
    logic [9:0]         num_taps;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] pixel_in;
    logic signed [15:0] kernel_in;
    logic               mac_start;
    logic               mac_rst_n;
    logic signed [15:0] mac_pixel;
    logic signed [15:0] mac_kernel;
    logic signed [31:0] mac_result = '0;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] result;

    int     n_cmp = 0;
    int     n_mis = 0;
    int     n_start_pulse = 0;
    int     n_clr_pulse = 0;
    int     px [1024];
    int     kn [1024];
    longint sb_q [$];

    mac_ctrl dut (
        .clk_gated  (clk_gated),
        .rst        (rst),
        .start      (start),
        .num_taps   (num_taps),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_in   (pixel_in),
        .kernel_in  (kernel_in),
        .mac_start  (mac_start),
        .mac_rst_n  (mac_rst_n),
        .mac_pixel  (mac_pixel),
        .mac_kernel (mac_kernel),
        .mac_result (mac_result),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    always #5 clk_gated = ~clk_gated;

    // Behavioural accumulator driven by the controller's datapath controls.
    always @(posedge clk_gated) begin
        if (!mac_rst_n) mac_result <= '0;
        else if (mac_start) mac_result <= mac_result + mac_pixel * mac_kernel;
    end

    // Pulse monitors for accumulate enables and accumulator clears.
    always @(posedge clk_gated) begin
        if (mac_start) n_start_pulse++;
        if (rst && !mac_rst_n) n_clr_pulse++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Runs one job from a negedge; returns at the negedge where out_valid is first seen.
    task automatic do_job(input int n, input bit toggle, input bit ordy, input int budget, output int lat);
        longint ev = 0;
        int     idx = 0;
        for (int i = 0; i < n; i++) ev += longint'(px[i]) * longint'(kn[i]);
`ifdef MAC_CTRL_RELU_EN
        if (ev < 0) ev = 0;
`endif
        sb_q.push_back(ev);
        lat       = -1;
        start     = 1'b1;
        num_taps  = 10'(n);
        out_ready = ordy;
        in_valid  = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk_gated);
            start = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
            in_valid  = (idx < n) && (!toggle || (k % 2 == 0));
            pixel_in  = 16'(px[idx < 1024 ? idx : 0]);
            kernel_in = 16'(kn[idx < 1024 ? idx : 0]);
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        if (lat < 0) chk("job_timeout_out_valid", out_valid, 1);
        else chk("result", result, sb_q.pop_front());
    endtask

    initial begin
        int lat;
        int base_s;
        int base_c;
        int seen;

        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        num_taps  = '0;
        pixel_in  = '0;
        kernel_in = '0;

        // Reset state
        @(negedge clk_gated);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mac_start", mac_start, 0);
        chk("rst_mac_rst_n", mac_rst_n, 0);
        chk("rst_result", result, 0);
        @(negedge clk_gated);
        rst = 1'b1;
        @(negedge clk_gated);
        chk("idle_mac_rst_n", mac_rst_n, 1);

        // Three taps, in_valid held high
        px[0] = 2;  kn[0] = 3;
        px[1] = -4; kn[1] = 5;
        px[2] = 6;  kn[2] = 7;
        base_s = n_start_pulse;
        base_c = n_clr_pulse;
        do_job(3, 1'b0, 1'b1, 20, lat);
        chk("a_latency", lat, 6);
        chk("a_mac_start_cnt", n_start_pulse - base_s, 3);
        chk("a_clr_cnt", n_clr_pulse - base_c, 1);
        @(negedge clk_gated);
        chk("a_idle_busy", busy, 0);

        // Four taps with in_valid toggling
        px[0] = 1;  kn[0] = -2;
        px[1] = 3;  kn[1] = 4;
        px[2] = -5; kn[2] = -6;
        px[3] = 7;  kn[3] = 8;
        base_s = n_start_pulse;
        do_job(4, 1'b1, 1'b1, 30, lat);
        chk("b_latency", lat, 10);
        chk("b_mac_start_cnt", n_start_pulse - base_s, 4);
        @(negedge clk_gated);

        // Zero taps
        base_s = n_start_pulse;
        base_c = n_clr_pulse;
        do_job(0, 1'b0, 1'b1, 20, lat);
        chk("c_latency", lat, 2);
        chk("c_mac_start_cnt", n_start_pulse - base_s, 0);
        chk("c_clr_cnt", n_clr_pulse - base_c, 1);
        @(negedge clk_gated);

        // Back-pressure on the result, start ignored while DONE
        px[0] = 5;  kn[0] = 6;
        px[1] = -1; kn[1] = 2;
        base_s = n_start_pulse;
        do_job(2, 1'b0, 1'b0, 20, lat);
        for (int i = 0; i < 5; i++) begin
            start    = (i == 2);
            num_taps = 10'd7;
            @(negedge clk_gated);
            chk("d_hold_result", result, 28);
            chk("d_hold_busy", busy, 1);
            chk("d_hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        num_taps  = 10'd3;
        @(negedge clk_gated);
        start = 1'b0;
        chk("d_release_busy", busy, 0);
        @(negedge clk_gated);
        chk("d_start_ignored_busy", busy, 0);
        chk("d_mac_start_cnt", n_start_pulse - base_s, 2);

        // Abort after one of five taps
        base_s   = n_start_pulse;
        start    = 1'b1;
        num_taps = 10'd5;
        @(negedge clk_gated);
        start     = 1'b0;
        in_valid  = 1'b1;
        pixel_in  = 16'sd9;
        kernel_in = 16'sd9;
        @(negedge clk_gated);
        @(negedge clk_gated);
        abort = 1'b1;
        #1;
        chk("e_abort_in_ready", in_ready, 0);
        chk("e_abort_mac_start", mac_start, 0);
        chk("e_abort_mac_rst_n", mac_rst_n, 0);
        chk("e_mac_start_cnt", n_start_pulse - base_s, 1);
        @(negedge clk_gated);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("e_after_abort_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_gated);
            if (out_valid) seen++;
        end
        chk("e_no_out_valid", seen, 0);
        px[0] = 3; kn[0] = 3;
        do_job(1, 1'b0, 1'b1, 20, lat);
        chk("e_next_latency", lat, 4);
        @(negedge clk_gated);

        // Negative accumulator value
        px[0] = -3; kn[0] = 4;
        do_job(1, 1'b0, 1'b1, 20, lat);
        @(negedge clk_gated);

        // Reset asserted mid-job
        px[0] = 1; kn[0] = 1;
        start    = 1'b1;
        num_taps = 10'd3;
        @(negedge clk_gated);
        start    = 1'b0;
        in_valid = 1'b1;
        pixel_in = 16'sd1;
        kernel_in = 16'sd1;
        @(negedge clk_gated);
        @(negedge clk_gated);
        #2 rst = 1'b0;
        #1;
        chk("g_rst_busy", busy, 0);
        chk("g_rst_mac_rst_n", mac_rst_n, 0);
        chk("g_rst_in_ready", in_ready, 0);
        chk("g_rst_result", result, 0);
        @(negedge clk_gated);
        rst      = 1'b1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_gated);
            if (out_valid || busy) seen++;
        end
        chk("g_no_job_after_rst", seen, 0);

        // Maximum tap count
        for (int i = 0; i < 1023; i++) begin
            px[i] = (i % 7) - 3;
            kn[i] = (i % 5) - 2;
        end
        base_s = n_start_pulse;
        do_job(1023, 1'b0, 1'b1, 1100, lat);
        chk("h_latency", lat, 1026);
        chk("h_mac_start_cnt", n_start_pulse - base_s, 1023);
        @(negedge clk_gated);
        chk("h_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand width.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width (2*DATA_W).
REQ-003 SHALL have parameter TAP_W, default 10, width of tap count.
REQ-004 clk_gated  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a dot product.
REQ-007 num_taps  in  TAP_W  products to accumulate; sampled only when start is accepted.
REQ-008 abort  in  1  synchronous cancel of the current job.
REQ-009 in_valid  in  1  operand pair valid.
REQ-010 in_ready  out  1  controller accepts operand pair.
REQ-011 pixel_in, kernel_in  in  DATA_W each  signed operands.
REQ-012 mac_start  out  1  datapath accumulate enable.
REQ-013 mac_rst_n  out  1  datapath accumulator clear, active-low.
REQ-014 mac_pixel, mac_kernel  out  DATA_W each  operands to datapath.
REQ-015 mac_result  in  ACC_W  datapath accumulator value.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-018 result  out  ACC_W  signed captured result.

Function
REQ-019 SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 latches num_taps, goes to CLEAR next cycle; start in any other state SHALL be ignored.
REQ-021 CLEAR: exactly one cycle, mac_rst_n=0; next RUN if latched taps>0, else DONE with result=0.
REQ-022 RUN: in_ready=1; mac_start=in_valid&in_ready combinationally; mac_pixel/mac_kernel=pixel_in/kernel_in combinationally.
REQ-023 RUN: tap counter increments on each accepted pair; acceptance of pair number num_taps moves to DRAIN; in_valid low stalls without counting.
REQ-024 DRAIN: one cycle, no acceptance; at its end result<=mac_result, then DONE.
REQ-025 DONE: out_valid=1, result held stable; out_valid&out_ready returns to IDLE next cycle; start in that same cycle is ignored.
REQ-026 in_ready, mac_start SHALL be 0 outside RUN; mac_rst_n SHALL be 1 outside CLEAR and abort.
REQ-027 Latency from start to out_valid SHALL be num_taps+3 cycles with in_valid held high.
REQ-028 abort in any non-IDLE state: mac_rst_n=0 that cycle, no acceptance, no out_valid, IDLE next cycle; abort beats start and out_ready.
REQ-029 num_taps=2^TAP_W-1 SHALL count correctly without wrap; counter width TAP_W.

Reset
REQ-030 rst low SHALL immediately force IDLE, counter 0, result 0, busy/out_valid/in_ready/mac_start 0, mac_rst_n 0.
REQ-031 rst asserted mid-job SHALL discard the job; no out_valid after release until a new start.

Configuration
REQ-032 With MAC_CTRL_RELU_EN defined, a negative mac_result SHALL be captured as 0 in DRAIN.
REQ-033 Without MAC_CTRL_RELU_EN, mac_result SHALL be captured unmodified.

Structure
REQ-034 Package mac_pkg SHALL hold the state enum, DATA_W/ACC_W/TAP_W defaults.
REQ-035 Tap counter SHALL be sub-module mac_tap_cnt (clear, enable, terminal-count flag).

Verification
REQ-036 num_taps=3, pairs (2,3),(-4,5),(6,7), in_valid high -> result 28 after 6 cycles, 3 mac_start pulses.
REQ-037 num_taps=4, in_valid toggled 1/0 -> mac_start exactly 4 times, latency 10 cycles, result equals reference sum.
REQ-038 num_taps=0 -> one mac_rst_n pulse, out_valid with result 0, no mac_start.
REQ-039 num_taps=2, out_ready held low 5 cycles -> result stable, busy high; start ignored; release -> IDLE.
REQ-040 abort after 1 of 5 taps -> mac_rst_n low, IDLE next cycle, no out_valid; next job num_taps=1 (3,3) -> 9.
REQ-041 pair (-3,4) num_taps=1 -> result 0 with MAC_CTRL_RELU_EN, -12 without.
